// File: rtl/digit_serial_addsub_if.sv
// rtl/digit_serial_addsub_if.sv - operand/result handshake bundle for digit_serial_addsub
interface digit_serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/digit_serial_addsub.sv
// rtl/digit_serial_addsub.sv - CHUNK-bit-per-cycle adder/subtractor with registered inter-chunk carry
// Optional result saturation on signed overflow under DIGIT_SERIAL_ADDSUB_SATURATE_EN.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_addsub_if.slave io
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry_r, cout_r, ovf_r;
  logic [KW-1:0]    k_r;
  logic [CHUNK-1:0] a_c, b_c, s_c;
  logic [CHUNK:0]   cv;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    io.in_ready  = 1'b0;
    io.busy      = 1'b0;
    io.out_valid = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        io.in_ready = rst_n;
        if (io.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        io.busy = 1'b1;
        if (k_r == KLAST) state_nxt = DONE;
      end
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pick the current operand chunk with constant part-selects only.
  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_r == KW'(i)) begin
        a_c = a_r[i*CHUNK +: CHUNK];
        b_c = b_r[i*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    cv    = '0;
    s_c   = '0;
    cv[0] = carry_r;
    for (int i = 0; i < CHUNK; i++) begin
      s_c[i]  = a_c[i] ^ b_c[i] ^ cv[i];
      cv[i+1] = (a_c[i] & b_c[i]) | (cv[i] & (a_c[i] ^ b_c[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      k_r     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      a_r     <= io.a;
      b_r     <= io.sub ? ~io.b : io.b;
      carry_r <= io.sub | io.cin;
      k_r     <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (k_r == KW'(i)) sum_r[i*CHUNK +: CHUNK] <= s_c;
      end
      carry_r <= cv[CHUNK];
      k_r     <= k_r + 1'b1;
      if (k_r == KLAST) begin
        cout_r <= cv[CHUNK];
        ovf_r  <= cv[CHUNK-1] ^ cv[CHUNK];
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
        // Clamp toward the sign of A; this overrides the final chunk write above.
        if (cv[CHUNK-1] ^ cv[CHUNK])
          sum_r <= a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      end
    end
  end

  assign io.sum  = sum_r;
  assign io.cout = cout_r;
  assign io.ovf  = ovf_r;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb/tb_digit_serial_addsub.sv - directed and swept checks of digit_serial_addsub in three geometries
module tb_digit_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  digit_serial_addsub_if #(.WIDTH(16)) i0 ();
  digit_serial_addsub_if #(.WIDTH(16)) i1 ();
  digit_serial_addsub_if #(.WIDTH(8))  i2 ();

  digit_serial_addsub #(.WIDTH(16), .CHUNK(4))  dut0 (.clk(clk), .rst_n(rst_n), .io(i0.slave));
  digit_serial_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (.clk(clk), .rst_n(rst_n), .io(i1.slave));
  digit_serial_addsub #(.WIDTH(8),  .CHUNK(1))  dut2 (.clk(clk), .rst_n(rst_n), .io(i2.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb, input logic ordy);
    case (d)
      0: begin
        i0.in_valid = v; i0.a = av; i0.b = bv; i0.cin = ci; i0.sub = sb; i0.out_ready = ordy;
      end
      1: begin
        i1.in_valid = v; i1.a = av; i1.b = bv; i1.cin = ci; i1.sub = sb; i1.out_ready = ordy;
      end
      default: begin
        i2.in_valid = v; i2.a = av[7:0]; i2.b = bv[7:0]; i2.cin = ci; i2.sub = sb; i2.out_ready = ordy;
      end
    endcase
  endtask

  task automatic peek(input int d, output logic [15:0] s, output logic co, output logic ov,
                      output logic ovld, output logic irdy, output logic bsy);
    case (d)
      0: begin
        s = i0.sum; co = i0.cout; ov = i0.ovf; ovld = i0.out_valid; irdy = i0.in_ready; bsy = i0.busy;
      end
      1: begin
        s = i1.sum; co = i1.cout; ov = i1.ovf; ovld = i1.out_valid; irdy = i1.in_ready; bsy = i1.busy;
      end
      default: begin
        s = {8'h00, i2.sum}; co = i2.cout; ov = i2.ovf; ovld = i2.out_valid; irdy = i2.in_ready; bsy = i2.busy;
      end
    endcase
  endtask

  // One full transaction: accept, scramble inputs, wait for out_valid, drain.
  task automatic run_op(input int d, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic sb, output logic [15:0] s, output logic co, output logic ov,
                        output int lat, output int bcnt);
    logic ovld, irdy, bsy;
    drive(d, 1'b1, av, bv, ci, sb, 1'b1);
    @(posedge clk); #1;
    drive(d, 1'b0, ~av, ~bv, ~ci, ~sb, 1'b1);
    lat  = 0;
    bcnt = 0;
    peek(d, s, co, ov, ovld, irdy, bsy);
    while (!ovld && lat < 40) begin
      if (bsy) bcnt++;
      @(posedge clk); #1;
      lat++;
      peek(d, s, co, ov, ovld, irdy, bsy);
    end
    @(posedge clk); #1;
  endtask

  task automatic ref_model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                           input logic sb, output logic [15:0] s, output logic co, output logic ov);
    logic [16:0] full;
    logic [15:0] mask, am, bb;
    mask = 16'((32'd1 << w) - 1);
    am   = av & mask;
    bb   = (sb ? ~bv : bv) & mask;
    full = {1'b0, am} + {1'b0, bb} + {16'h0, (sb ? 1'b1 : ci)};
    s    = full[15:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
    if (ov) s = am[w-1] ? (16'h1 << (w - 1)) : (mask >> 1);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] s, es, ra, rb;
    logic co, ov, ovld, irdy, bsy, eco, eov, rc, rs;
    int lat, bcnt;

    for (int d = 0; d < 3; d++) drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    peek(0, s, co, ov, ovld, irdy, bsy);
    check("rst_in_ready", 32'(irdy), 32'd1);
    check("rst_out_valid", 32'(ovld), 32'd0);
    check("rst_busy", 32'(bsy), 32'd0);
    check("rst_sum", 32'(s), 32'h0);
    check("rst_cout", 32'(co), 32'd0);
    check("rst_ovf", 32'(ov), 32'd0);

    run_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, s, co, ov, lat, bcnt);
    check("add1_sum", 32'(s), 32'h2233);
    check("add1_cout", 32'(co), 32'd0);
    check("add1_ovf", 32'(ov), 32'd0);
    check("add1_latency", 32'(lat), 32'd4);
    check("add1_busy_cycles", 32'(bcnt), 32'd4);

    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, bcnt);
    check("carry_sum", 32'(s), 32'h0000);
    check("carry_cout", 32'(co), 32'd1);
    check("carry_ovf", 32'(ov), 32'd0);
    run_op(0, 16'h0000, 16'h0000, 1'b1, 1'b0, s, co, ov, lat, bcnt);
    check("cin_sum", 32'(s), 32'h0001);
    check("cin_cout", 32'(co), 32'd0);

    run_op(0, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, s, co, ov, lat, bcnt);
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
    check("subovf_sum", 32'(s), 32'h7FFF);
`else
    check("subovf_sum", 32'(s), 32'h8000);
`endif
    check("subovf_cout", 32'(co), 32'd0);
    check("subovf_ovf", 32'(ov), 32'd1);
    run_op(0, 16'h0005, 16'h0005, 1'b1, 1'b1, s, co, ov, lat, bcnt);
    check("subeq_sum", 32'(s), 32'h0000);
    check("subeq_cout", 32'(co), 32'd1);
    check("subeq_ovf", 32'(ov), 32'd0);

    // Backpressure: result held while new operands wait on in_valid.
    drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0);
    lat = 0;
    peek(0, s, co, ov, ovld, irdy, bsy);
    while (!ovld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      peek(0, s, co, ov, ovld, irdy, bsy);
    end
    check("bp_latency", 32'(lat), 32'd4);
    check("bp_sum_first", 32'(s), 32'h3333);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      peek(0, s, co, ov, ovld, irdy, bsy);
      check("bp_hold_out_valid", 32'(ovld), 32'd1);
      check("bp_hold_sum", 32'(s), 32'h3333);
      check("bp_hold_cout", 32'(co), 32'd0);
      check("bp_hold_ovf", 32'(ov), 32'd0);
      check("bp_hold_in_ready", 32'(irdy), 32'd0);
    end
    i0.out_ready = 1'b1;
    @(posedge clk); #1;
    peek(0, s, co, ov, ovld, irdy, bsy);
    check("bp_release_in_ready", 32'(irdy), 32'd1);
    check("bp_release_out_valid", 32'(ovld), 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    peek(0, s, co, ov, ovld, irdy, bsy);
    check("bp_held_accept_busy", 32'(bsy), 32'd1);
    lat = 0;
    while (!ovld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      peek(0, s, co, ov, ovld, irdy, bsy);
    end
    check("bp_held_latency", 32'(lat), 32'd4);
    check("bp_held_sum", 32'(s), 32'h0300);
    @(posedge clk); #1;

    // Reset while the third chunk is being computed.
    drive(0, 1'b1, 16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    peek(0, s, co, ov, ovld, irdy, bsy);
    check("abort_out_valid", 32'(ovld), 32'd0);
    check("abort_sum", 32'(s), 32'h0);
    check("abort_busy", 32'(bsy), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    peek(0, s, co, ov, ovld, irdy, bsy);
    check("abort_in_ready", 32'(irdy), 32'd1);
    check("abort_out_valid_after", 32'(ovld), 32'd0);
    run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, bcnt);
    check("post_abort_sum", 32'(s), 32'h0002);
    check("post_abort_latency", 32'(lat), 32'd4);

    for (int d = 0; d < 3; d++) begin
      int w, nl;
      w  = (d == 2) ? 8 : 16;
      nl = (d == 0) ? 4 : ((d == 1) ? 1 : 8);
      for (int n = 0; n < 200; n++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        run_op(d, ra, rb, rc, rs, s, co, ov, lat, bcnt);
        ref_model(w, ra, rb, rc, rs, es, eco, eov);
        check($sformatf("sweep%0d_sum", d), 32'(s), 32'(es));
        check($sformatf("sweep%0d_cout", d), 32'(co), 32'(eco));
        check($sformatf("sweep%0d_ovf", d), 32'(ov), 32'(eov));
        check($sformatf("sweep%0d_latency", d), 32'(lat), 32'(nl));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
